cp0_exc: RTL and testbench

Coprocessor-0 exception controller for the five-stage MIPS pipeline. It takes the exception code, delay-slot flag and PC of the instruction at the commit point (M stage), plus the external hardware interrupt lines. It decides whether to take an exception or interrupt and drives the pipeline-wide `int_req` that flushes the stage registers and redirects fetch to 0x0000_4180. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0`/`eret`.

---
 rtl/cp0_exc.sv | 116 +++++++++++
 tb/tb_cp0_exc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc.sv
// cp0_exc: coprocessor-0 exception controller. Holds SR, Cause, EPC and PRId,
// decides exception/interrupt entry at the M-stage commit point and drives
// the pipeline-wide int_req used to flush stages and redirect fetch.
module cp0_exc #(
   parameter logic [31:0] PRID = 32'h0000_0007
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [31:0] pc_in,
   input  logic        bd_in,
   input  logic [4:0]  exccode_in,
   input  logic [5:0]  hwint,
   input  logic        eret_in,
   output logic        int_req,
   output logic [31:0] epc_out
);

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;

   logic        irq;
   logic        exc;
   logic [31:0] pc_al;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   // Entry decision: unmasked interrupt or committing exception, both blocked while EXL is set
   always_comb begin
      irq     = (|(hwint & im_q)) & ie_q & ~exl_q;
      exc     = (exccode_in != 5'd0) & ~exl_q;
      int_req = irq | exc;
   end

   // EPC candidate: word-aligned PC, backed up one word for a delay-slot instruction (wraps mod 2^32)
   always_comb begin
      pc_al = pc_in & ~32'h0000_0003;
   end

   // Next-state: exception entry overrides mtc0/eret; Cause.IP always tracks hwint
   always_comb begin
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      ip_d      = hwint;
      if (int_req) begin
         exl_d     = 1'b1;
         exccode_d = irq ? 5'd0 : exccode_in;
         bd_d      = bd_in;
         epc_d     = bd_in ? (pc_al - 32'd4) : pc_al;
      end else begin
         if (en) begin
            case (addr)
               5'd12: begin
                  im_d  = wdata[15:10];
                  exl_d = wdata[1];
                  ie_d  = wdata[0];
               end
               5'd14: epc_d = wdata;
               default: ;
            endcase
         end
         if (eret_in) begin
            exl_d = 1'b0;
         end
      end
   end

   // CP0 state registers, cleared asynchronously on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q      <= 6'd0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= 6'd0;
         exccode_q <= 5'd0;
         epc_q     <= 32'd0;
      end else begin
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ip_q      <= ip_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
      end
   end

   // mfc0 read mux; unimplemented SR/Cause bits and unknown registers read zero
   always_comb begin
      sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
      cause_val = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      case (addr)
         5'd12:   rdata = sr_val;
         5'd13:   rdata = cause_val;
         5'd14:   rdata = epc_q;
         5'd15:   rdata = PRID;
         default: rdata = 32'd0;
      endcase
   end

   assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed bench for cp0_exc with a scoreboard queue of expected values.
module tb_cp0_exc;

   localparam logic [31:0] PRID_V = 32'h0000_0007;

   logic        clk;
   logic        reset;
   logic        en;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] pc_in;
   logic        bd_in;
   logic [4:0]  exccode_in;
   logic [5:0]  hwint;
   logic        eret_in;
   logic        int_req;
   logic [31:0] epc_out;

   cp0_exc #(.PRID(PRID_V)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .pc_in      (pc_in),
      .bd_in      (bd_in),
      .exccode_in (exccode_in),
      .hwint      (hwint),
      .eret_in    (eret_in),
      .int_req    (int_req),
      .epc_out    (epc_out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  passed = 0;
   int  total  = 0;

   task automatic push(input string tag, input logic [31:0] e);
      sb_t s;
      s.tag = tag;
      s.exp = e;
      sb.push_back(s);
   endtask

   task automatic chk(input logic [31:0] obs);
      sb_t s;
      total++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %h required an entry", obs);
      end else begin
         s = sb.pop_front();
         assert (obs === s.exp) passed++;
         else $error("FAIL %s: observed %h required %h", s.tag, obs, s.exp);
      end
   endtask

   task automatic exp_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
      push(tag, e);
      addr = a;
      #1;
      chk(rdata);
   endtask

   task automatic exp_irq(input string tag, input logic e);
      push(tag, {31'd0, e});
      #1;
      chk({31'd0, int_req});
   endtask

   task automatic exp_epc(input string tag, input logic [31:0] e);
      push(tag, e);
      #1;
      chk(epc_out);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      en = 1'b0; eret_in = 1'b0; exccode_in = 5'd0; bd_in = 1'b0;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; addr = 5'd0; wdata = 32'd0; pc_in = 32'd0;
      bd_in = 1'b0; exccode_in = 5'd0; hwint = 6'd0; eret_in = 1'b0;

      // Reset state
      #1;
      exp_irq("rst_int_req", 1'b0);
      exp_epc("rst_epc_out", 32'd0);
      exp_rd("rst_sr", 5'd12, 32'd0);
      exp_rd("rst_cause", 5'd13, 32'd0);
      exp_rd("rst_epc", 5'd14, 32'd0);
      exp_rd("rst_prid", 5'd15, PRID_V);
      exccode_in = 5'd3;
      exp_irq("rst_exc_req", 1'b1);
      exccode_in = 5'd0;
      reset = 1'b1;
      step;

      // Preload EPC and SR, let hwint reach Cause.IP
      en = 1'b1; addr = 5'd14; wdata = 32'h0000_3000;
      step;
      addr = 5'd12; wdata = 32'hFFFF_FFFF; hwint = 6'h15;
      step;
      en = 1'b0;
      exp_rd("pre_epc", 5'd14, 32'h0000_3000);
      exp_epc("pre_epc_out", 32'h0000_3000);
      exp_rd("pre_sr_mask", 5'd12, 32'h0000_FC03);
      exp_rd("pre_cause_ip", 5'd13, 32'h0000_5400);
      exp_rd("other_addr", 5'd3, 32'd0);

      // Asynchronous reset mid-cycle
      #2;
      reset = 1'b0;
      exp_rd("arst_epc", 5'd14, 32'd0);
      exp_rd("arst_sr", 5'd12, 32'd0);
      exp_rd("arst_cause", 5'd13, 32'd0);
      exp_rd("arst_prid", 5'd15, PRID_V);
      hwint = 6'd0;
      step;
      reset = 1'b1;
      step;

      // Plain exception
      exccode_in = 5'd12; pc_in = 32'h0000_3008; bd_in = 1'b0;
      exp_irq("exc_req", 1'b1);
      step;
      idle;
      exp_rd("exc_epc", 5'd14, 32'h0000_3008);
      exp_rd("exc_cause", 5'd13, 32'h0000_0030);
      exp_rd("exc_sr", 5'd12, 32'h0000_0002);

      // Delay slot with interrupt priority
      en = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
      step;
      en = 1'b0;
      exp_rd("sr_wr", 5'd12, 32'h0000_0401);
      hwint = 6'b000001; exccode_in = 5'd10; pc_in = 32'h0000_3014; bd_in = 1'b1;
      exp_irq("irq_req", 1'b1);
      step;
      idle; hwint = 6'd0;
      exp_rd("irq_cause", 5'd13, 32'h8000_0400);
      exp_rd("irq_epc", 5'd14, 32'h0000_3010);
      exp_rd("irq_sr", 5'd12, 32'h0000_0403);
      step;

      // Nested exception blocked while EXL=1
      exccode_in = 5'd4; hwint = 6'h3F; pc_in = 32'h0000_7000;
      exp_irq("nest_req", 1'b0);
      step;
      idle;
      exp_rd("nest_epc", 5'd14, 32'h0000_3010);
      exp_rd("nest_cause", 5'd13, 32'h8000_FC00);
      hwint = 6'd0;
      en = 1'b1; addr = 5'd12; wdata = 32'h0000_0000;
      step;

      // mtc0 EPC collides with an exception
      en = 1'b1; addr = 5'd14; wdata = 32'h0000_5000;
      exccode_in = 5'd8; pc_in = 32'h0000_3020; bd_in = 1'b0;
      exp_irq("coll_req", 1'b1);
      step;
      idle;
      exp_rd("coll_epc", 5'd14, 32'h0000_3020);
      exp_rd("coll_cause", 5'd13, 32'h0000_0020);

      // eret with a pending unmasked interrupt
      en = 1'b1; addr = 5'd12; wdata = 32'h0000_0403;
      step;
      en = 1'b0;
      hwint = 6'b000001;
      exp_irq("eret_pre_req", 1'b0);
      eret_in = 1'b1;
      step;
      eret_in = 1'b0;
      exp_rd("eret_sr", 5'd12, 32'h0000_0401);
      exp_irq("eret_post_req", 1'b1);
      hwint = 6'd0;
      exp_irq("hw_drop_req", 1'b0);

      // EPC wraps below zero for a delay-slot instruction at PC 0
      exccode_in = 5'd5; pc_in = 32'h0000_0000; bd_in = 1'b1;
      step;
      idle;
      exp_epc("wrap_epc", 32'hFFFF_FFFC);

      // Writes to Cause are ignored
      en = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
      step;
      en = 1'b0;
      exp_rd("cause_ro", 5'd13, 32'h8000_0014);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
